// File: rtl/data_sram_responder.sv
// Responder end of the CPU data_sram interface: word RAM with
// programmable wait states, stall handshake and request checking.
module data_sram_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [1:0]  data_sram_rlen,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_stall,
    output logic        data_sram_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WC    = 4'(WAIT_CYCLES);
    localparam int         DEPTH = 1 << ADDR_WIDTH;

    state_t state;
    state_t state_nx;
    logic [3:0]  cnt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wen;
    logic [1:0]  req_rlen;

    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wen;
    logic [1:0]  cur_rlen;
    logic        cur_wr;
    logic        bad;
    logic        stall_c;
    logic        enter_resp;
    logic [ADDR_WIDTH-1:0] idx;

    logic [31:0] mem [DEPTH];

    // With zero wait states RESP follows the accept edge directly,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        cur_addr  = req_addr;
        cur_wdata = req_wdata;
        cur_wen   = req_wen;
        cur_rlen  = req_rlen;
        if (state == S_IDLE) begin
            cur_addr  = data_sram_addr;
            cur_wdata = data_sram_wdata;
            cur_wen   = data_sram_wen;
            cur_rlen  = data_sram_rlen;
        end
    end

    assign cur_wr = |cur_wen;
    assign idx    = cur_addr[ADDR_WIDTH+1:2];

    // Window, size/alignment and write-lane legality check.
    always_comb begin
        bad = 1'b0;
        if (cur_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
            bad = 1'b1;
        if (!cur_wr) begin
            if (cur_rlen == 2'd3)
                bad = 1'b1;
            if (cur_rlen == 2'd1 && cur_addr[0])
                bad = 1'b1;
            if (cur_rlen == 2'd2 && cur_addr[1:0] != 2'b00)
                bad = 1'b1;
        end else begin
            unique case (cur_wen)
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0011, 4'b1100, 4'b1111: ;
                default: bad = 1'b1;
            endcase
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall_c = data_sram_en;
                if (data_sram_en)
                    state_nx = (WC == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (cnt <= 4'd1)
                    state_nx = S_RESP;
            end
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign data_sram_stall = stall_c & resetn;
    assign enter_resp      = resetn && (state_nx == S_RESP);

    // State, wait counter, request latch and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            cnt             <= 4'd0;
            req_addr        <= 32'd0;
            req_wdata       <= 32'd0;
            req_wen         <= 4'd0;
            req_rlen        <= 2'd0;
            data_sram_rdata <= 32'd0;
            data_sram_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && data_sram_en) begin
                req_addr  <= data_sram_addr;
                req_wdata <= data_sram_wdata;
                req_wen   <= data_sram_wen;
                req_rlen  <= data_sram_rlen;
                cnt       <= WC;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            data_sram_err <= enter_resp & bad;
            if (enter_resp)
                data_sram_rdata <= (bad || cur_wr) ? 32'd0 : mem[idx];
        end
    end

    // Byte-lane RAM write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_wr && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wen[i])
                    mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: one instance with one wait state,
// one with none; table vectors plus back-to-back and reset sequences.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en1;
    logic        en0;
    logic [1:0]  rlen;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata0;
    logic        stall1;
    logic        stall0;
    logic        err1;
    logic        err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_responder #(
        .ADDR_WIDTH(12),
        .BASE_ADDR(32'h0000_0000),
        .WAIT_CYCLES(1)
    ) dut1 (
        .clk(clk),
        .resetn(resetn),
        .data_sram_en(en1),
        .data_sram_rlen(rlen),
        .data_sram_wen(wen),
        .data_sram_addr(addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata1),
        .data_sram_stall(stall1),
        .data_sram_err(err1)
    );

    data_sram_responder #(
        .ADDR_WIDTH(12),
        .BASE_ADDR(32'h0000_0000),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk),
        .resetn(resetn),
        .data_sram_en(en0),
        .data_sram_rlen(rlen),
        .data_sram_wen(wen),
        .data_sram_addr(addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata0),
        .data_sram_stall(stall0),
        .data_sram_err(err0)
    );

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        logic [1:0]  rl;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic stall_of(input bit sel);
        return sel ? stall1 : stall0;
    endfunction

    task automatic req(input bit sel, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] d,
                       input logic [1:0] rl, input logic [31:0] exp_rd,
                       input logic exp_err, input string nm);
        int n;
        int expn;
        expn = sel ? 2 : 1;
        @(negedge clk);
        addr  = a;
        wen   = w;
        wdata = d;
        rlen  = rl;
        if (sel) en1 = 1'b1;
        else     en0 = 1'b1;
        n = 0;
        #1;
        while (stall_of(sel) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, " stall_cycles"}, 32'(n), 32'(expn));
        check({nm, " rdata"}, sel ? rdata1 : rdata0, exp_rd);
        check({nm, " err"}, 32'(sel ? err1 : err0), 32'(exp_err));
        en1 = 1'b0;
        en0 = 1'b0;
        @(posedge clk);
        #1;
        check({nm, " err_pulse_end"}, 32'(sel ? err1 : err0), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1, 32'h10, 4'hF, 32'h11223344, 2, 32'h0, 0};
        vecs[1]  = '{1, 32'h10, 4'h0, 32'h0, 2, 32'h11223344, 0};
        vecs[2]  = '{1, 32'h10, 4'h4, 32'hAAAAAAAA, 0, 32'h0, 0};
        vecs[3]  = '{1, 32'h10, 4'h0, 32'h0, 2, 32'h11AA3344, 0};
        vecs[4]  = '{1, 32'h12, 4'hC, 32'hBEEFBEEF, 1, 32'h0, 0};
        vecs[5]  = '{1, 32'h10, 4'h0, 32'h0, 2, 32'hBEEF3344, 0};
        vecs[6]  = '{1, 32'h00, 4'hF, 32'h01020304, 2, 32'h0, 0};
        vecs[7]  = '{1, 32'h10000, 4'hF, 32'hFFFFFFFF, 2, 32'h0, 1};
        vecs[8]  = '{1, 32'h00, 4'h0, 32'h0, 2, 32'h01020304, 0};
        vecs[9]  = '{1, 32'h06, 4'h0, 32'h0, 2, 32'h0, 1};
        vecs[10] = '{1, 32'h10, 4'h0, 32'h0, 3, 32'h0, 1};
        vecs[11] = '{1, 32'h10, 4'h6, 32'h0, 2, 32'h0, 1};
        vecs[12] = '{1, 32'h10, 4'h0, 32'h0, 2, 32'hBEEF3344, 0};
        vecs[13] = '{1, 32'h11, 4'h0, 32'h0, 1, 32'h0, 1};
        vecs[14] = '{1, 32'h13, 4'h0, 32'h0, 0, 32'hBEEF3344, 0};
        vecs[15] = '{1, 32'h20, 4'hF, 32'h55667788, 2, 32'h0, 0};
        vecs[16] = '{0, 32'h00, 4'hF, 32'hCAFEF00D, 2, 32'h0, 0};
        vecs[17] = '{0, 32'h04, 4'hF, 32'h12345678, 2, 32'h0, 0};
        vecs[18] = '{1, 32'h3FFC, 4'hF, 32'h0BADC0DE, 2, 32'h0, 0};
        vecs[19] = '{1, 32'h3FFC, 4'h0, 32'h0, 2, 32'h0BADC0DE, 0};
        vecs[20] = '{1, 32'h12, 4'h0, 32'h0, 1, 32'hBEEF3344, 0};

        resetn = 1'b0;
        en1    = 1'b0;
        en0    = 1'b0;
        rlen   = 2'd0;
        wen    = 4'd0;
        addr   = 32'd0;
        wdata  = 32'd0;
        #1;
        check("reset stall", 32'(stall1), 32'd0);
        check("reset rdata", rdata1, 32'd0);
        check("reset err", 32'(err1), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req(vecs[i].sel, vecs[i].a, vecs[i].w, vecs[i].d,
                vecs[i].rl, vecs[i].exp_rd, vecs[i].exp_err,
                $sformatf("vec%0d", i));
        end

        // zero-wait back-to-back reads with en held high
        @(negedge clk);
        addr = 32'h0;
        wen  = 4'h0;
        rlen = 2'd2;
        en0  = 1'b1;
        #1;
        check("b2b accept1 stall", 32'(stall0), 32'd1);
        @(posedge clk);
        #1;
        check("b2b resp1 stall", 32'(stall0), 32'd0);
        check("b2b resp1 rdata", rdata0, 32'hCAFEF00D);
        addr = 32'h4;
        @(posedge clk);
        #1;
        check("b2b accept2 stall", 32'(stall0), 32'd1);
        @(posedge clk);
        #1;
        check("b2b resp2 stall", 32'(stall0), 32'd0);
        check("b2b resp2 rdata", rdata0, 32'h12345678);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        check("b2b idle stall", 32'(stall0), 32'd0);

        // reset during the wait state of a write
        @(negedge clk);
        addr  = 32'h20;
        wen   = 4'hF;
        wdata = 32'hDEADBEEF;
        rlen  = 2'd2;
        en1   = 1'b1;
        @(posedge clk);
        #1;
        check("rst wait stall", 32'(stall1), 32'd1);
        resetn = 1'b0;
        en1    = 1'b0;
        #1;
        check("rst stall", 32'(stall1), 32'd0);
        check("rst rdata", rdata1, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        req(1, 32'h20, 4'h0, 32'h0, 2, 32'h55667788, 0, "post_rst_lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
